alu_exec_seq: RTL and testbench

Sequential, parametrised successor to the combinational ALU control block. It accepts one operation per handshake: ALU group code, funct3, funct7, immediate flag and two WIDTH-bit operands. It decodes these to the 4-bit ALU opcode, executes the operation, and returns a registered result through a valid/ready output. Shifts are iterative, SHIFT_STEP bits per cycle, so the block stalls upstream until the result is taken. It sits between the decode stage and writeback/branch logic of the core.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_op_decode.sv | 62 ++++++
 rtl/alu_exec_seq.sv | 126 ++++++++++++
 tb/tb_alu_exec_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, group and FSM encodings for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_SUM   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b1010;
  localparam logic [3:0] OP_EQUAL = 4'b0011;
  localparam logic [3:0] OP_GE    = 4'b1100;
  localparam logic [3:0] OP_GEU   = 4'b1101;
  localparam logic [3:0] OP_SLT   = 4'b1110;
  localparam logic [3:0] OP_SLTU  = 4'b1111;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b0111;

  localparam logic [1:0] CO_LDST   = 2'b00;
  localparam logic [1:0] CO_BRANCH = 2'b01;
  localparam logic [1:0] CO_ALU    = 2'b10;
  localparam logic [1:0] CO_INV    = 2'b11;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of group/funct fields to the 4-bit ALU opcode.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] ALU_CO_i,
  input  logic [6:0] FUNC7_i,
  input  logic [2:0] FUNC3_i,
  input  logic       is_immediate_i,
  output logic [3:0] op_o,
  output logic       is_shift_o,
  output logic       illegal_o
);

  logic [3:0] w_op;
  logic       w_illegal;

  // Opcode selection; illegal encodings collapse to opcode 0000.
  always_comb begin
    w_op      = OP_AND;
    w_illegal = 1'b0;
    case (ALU_CO_i)
      CO_LDST: w_op = OP_SUM;
      CO_BRANCH: begin
        case (FUNC3_i)
          3'b000, 3'b001: w_op = OP_EQUAL;
          3'b100:         w_op = OP_SLT;
          3'b101:         w_op = OP_GE;
          3'b110:         w_op = OP_SLTU;
          3'b111:         w_op = OP_GEU;
          default:        w_illegal = 1'b1;
        endcase
      end
      CO_ALU: begin
        case (FUNC3_i)
          3'b000: begin
            if (is_immediate_i || FUNC7_i == F7_ZERO) w_op = OP_SUM;
            else if (FUNC7_i == F7_ALT)               w_op = OP_SUB;
            else                                      w_illegal = 1'b1;
          end
          3'b001: w_op = OP_SLL;
          3'b010: w_op = OP_SLT;
          3'b011: w_op = OP_SLTU;
          3'b100: w_op = OP_XOR;
          3'b101: begin
            if (FUNC7_i == F7_ZERO)     w_op = OP_SRL;
            else if (FUNC7_i == F7_ALT) w_op = OP_SRA;
            else                        w_illegal = 1'b1;
          end
          3'b110: w_op = OP_OR;
          default: w_op = OP_AND;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) w_op = OP_AND;
  end

  assign op_o       = w_op;
  assign illegal_o  = w_illegal;
  assign is_shift_o = !w_illegal && (w_op == OP_SLL || w_op == OP_SRL || w_op == OP_SRA);

endmodule

// File: rtl/alu_exec_seq.sv
// Sequential ALU: handshake in, single-cycle or iterative-shift execute,
// registered result out through valid/ready.
module alu_exec_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             is_immediate_i,
  input  logic [1:0]       ALU_CO_i,
  input  logic [6:0]       FUNC7_i,
  input  logic [2:0]       FUNC3_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       ALU_OP_o,
  output logic             illegal_o
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_op;
  logic             r_illegal;
  logic [SHW:0]     r_remaining;

  logic [3:0]       w_op;
  logic             w_is_shift;
  logic             w_illegal;
  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic [SHW:0]     w_step;
  logic [WIDTH-1:0] w_shifted;

  alu_op_decode u_decode (
    .ALU_CO_i       (ALU_CO_i),
    .FUNC7_i        (FUNC7_i),
    .FUNC3_i        (FUNC3_i),
    .is_immediate_i (is_immediate_i),
    .op_o           (w_op),
    .is_shift_o     (w_is_shift),
    .illegal_o      (w_illegal)
  );

  assign in_ready_o  = (r_state == ST_IDLE) || (r_state == ST_DONE && out_ready_i);
  assign out_valid_o = (r_state == ST_DONE);
  assign result_o    = r_result;
  assign ALU_OP_o    = r_op;
  assign illegal_o   = r_illegal;
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_shamt     = b_i[SHW-1:0];

  // Single-cycle datapath; comparisons return 0/1 in bit 0.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_AND:   w_alu = a_i & b_i;
      OP_OR:    w_alu = a_i | b_i;
      OP_XOR:   w_alu = a_i ^ b_i;
      OP_SUM:   w_alu = a_i + b_i;
      OP_SUB:   w_alu = a_i - b_i;
      OP_EQUAL: w_alu[0] = (a_i == b_i);
      OP_GE:    w_alu[0] = ($signed(a_i) >= $signed(b_i));
      OP_GEU:   w_alu[0] = (a_i >= b_i);
      OP_SLT:   w_alu[0] = ($signed(a_i) < $signed(b_i));
      OP_SLTU:  w_alu[0] = (a_i < b_i);
      default:  w_alu = '0;
    endcase
  end

  // One shift iteration of min(SHIFT_STEP, remaining) bits.
  always_comb begin
    w_step = (r_remaining < STEP) ? r_remaining : STEP;
    case (r_op)
      OP_SLL:  w_shifted = r_result << w_step;
      OP_SRA:  w_shifted = $unsigned($signed(r_result) >>> w_step);
      default: w_shifted = r_result >> w_step;
    endcase
  end

  // Control FSM and output registers; accept from IDLE or DONE-with-handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_result    <= '0;
      r_op        <= '0;
      r_illegal   <= 1'b0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_illegal <= w_illegal;
      if (w_illegal) begin
        r_result <= '0;
        r_state  <= ST_DONE;
      end else if (w_is_shift && w_shamt != '0) begin
        r_result    <= a_i;
        r_remaining <= {1'b0, w_shamt};
        r_state     <= ST_SHIFT;
      end else begin
        r_result <= w_is_shift ? a_i : w_alu;
        r_state  <= ST_DONE;
      end
    end else begin
      case (r_state)
        ST_SHIFT: begin
          r_result    <= w_shifted;
          r_remaining <= r_remaining - w_step;
          if (r_remaining == w_step) r_state <= ST_DONE;
        end
        ST_DONE:  if (out_ready_i) r_state <= ST_IDLE;
        ST_IDLE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Table-driven bench with a result scoreboard for alu_exec_seq.
module tb_alu_exec_seq;

  typedef struct {
    logic [1:0]  co;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  op;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  op;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imm = 1'b0;
  logic [1:0]  co = 2'b00;
  logic [6:0]  f7 = '0;
  logic [2:0]  f3 = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  alu_op;
  logic        illegal;

  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic        out_valid4;
  logic        out_ready4 = 1'b1;
  logic [31:0] result4;
  logic [3:0]  alu_op4;
  logic        illegal4;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned pushed = 0;
  int unsigned delivered = 0;
  exp_t        sbq[$];
  vec_t        vecs[22];

  always #5 clk = ~clk;

  alu_exec_seq #(.WIDTH(32), .SHIFT_STEP(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .is_immediate_i(imm), .ALU_CO_i(co), .FUNC7_i(f7), .FUNC3_i(f3),
    .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .ALU_OP_o(alu_op), .illegal_o(illegal)
  );

  alu_exec_seq #(.WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .is_immediate_i(imm), .ALU_CO_i(co), .FUNC7_i(f7), .FUNC3_i(f3),
    .a_i(a), .b_i(b), .out_valid_o(out_valid4), .out_ready_i(out_ready4),
    .result_o(result4), .ALU_OP_o(alu_op4), .illegal_o(illegal4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] c, input logic [2:0] g3, input logic [6:0] g7,
                              input logic im, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] r, input logic [3:0] o, input logic il);
    vec_t v;
    v.co = c; v.f3 = g3; v.f7 = g7; v.imm = im; v.a = x; v.b = y;
    v.res = r; v.op = o; v.ill = il;
    return v;
  endfunction

  // Scoreboard: pop and compare whenever the DUT hands off a result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        delivered++;
        chk("sb_result", result, e.res);
        chk("sb_op", {28'd0, alu_op}, {28'd0, e.op});
        chk("sb_illegal", {31'd0, illegal}, {31'd0, e.ill});
      end
    end
  end

  task automatic drive(input vec_t v);
    co = v.co; f3 = v.f3; f7 = v.f7; imm = v.imm; a = v.a; b = v.b;
  endtask

  // Present a request and wait (bounded) for its accept edge; optionally score it.
  task automatic send(input vec_t v, input bit score);
    bit done;
    exp_t e;
    done = 1'b0;
    drive(v);
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (score) begin
          e.res = v.res; e.op = v.op; e.ill = v.ill;
          sbq.push_back(e);
          pushed++;
        end
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lat;
    int   rdy_hi;
    int   vcount;

    vecs[0]  = mk(2'b10, 3'b000, 7'b0100000, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b1010, 1'b0);
    vecs[1]  = mk(2'b10, 3'b000, 7'b0100000, 1'b1, 32'd5, 32'd7, 32'h0000_000C, 4'b0010, 1'b0);
    vecs[2]  = mk(2'b01, 3'b110, 7'd0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1, 4'b1111, 1'b0);
    vecs[3]  = mk(2'b01, 3'b100, 7'd0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'b1110, 1'b0);
    vecs[4]  = mk(2'b11, 3'b000, 7'd0, 1'b0, 32'd9, 32'd9, 32'd0, 4'b0000, 1'b1);
    vecs[5]  = mk(2'b01, 3'b010, 7'd0, 1'b0, 32'd9, 32'd9, 32'd0, 4'b0000, 1'b1);
    vecs[6]  = mk(2'b10, 3'b111, 7'd0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000, 1'b0);
    vecs[7]  = mk(2'b10, 3'b110, 7'd0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 4'b0001, 1'b0);
    vecs[8]  = mk(2'b10, 3'b100, 7'd0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 4'b1000, 1'b0);
    vecs[9]  = mk(2'b00, 3'b010, 7'd0, 1'b0, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_00FC, 4'b0010, 1'b0);
    vecs[10] = mk(2'b10, 3'b011, 7'd0, 1'b0, 32'd5, 32'd3, 32'd0, 4'b1111, 1'b0);
    vecs[11] = mk(2'b10, 3'b010, 7'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b1110, 1'b0);
    vecs[12] = mk(2'b01, 3'b000, 7'd0, 1'b0, 32'd7, 32'd7, 32'd1, 4'b0011, 1'b0);
    vecs[13] = mk(2'b01, 3'b101, 7'd0, 1'b0, 32'hFFFF_FFFE, 32'd1, 32'd0, 4'b1100, 1'b0);
    vecs[14] = mk(2'b01, 3'b111, 7'd0, 1'b0, 32'hFFFF_FFFE, 32'd1, 32'd1, 4'b1101, 1'b0);
    vecs[15] = mk(2'b10, 3'b001, 7'd0, 1'b0, 32'd1, 32'd31, 32'h8000_0000, 4'b0100, 1'b0);
    vecs[16] = mk(2'b10, 3'b101, 7'd0, 1'b0, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 4'b0101, 1'b0);
    vecs[17] = mk(2'b10, 3'b101, 7'b0100000, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b0111, 1'b0);
    vecs[18] = mk(2'b10, 3'b101, 7'd0, 1'b0, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 4'b0101, 1'b0);
    vecs[19] = mk(2'b10, 3'b101, 7'b0000001, 1'b0, 32'd8, 32'd1, 32'd0, 4'b0000, 1'b1);
    vecs[20] = mk(2'b10, 3'b000, 7'b0000001, 1'b0, 32'd3, 32'd4, 32'd0, 4'b0000, 1'b1);
    vecs[21] = mk(2'b10, 3'b000, 7'b0000001, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0010, 1'b0);

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_op", {28'd0, alu_op}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;

    // Table vectors, back-to-back with consumer always ready
    foreach (vecs[i]) send(vecs[i], 1'b1);
    drain();

    // Single-cycle latency for an illegal request
    v = vecs[4];
    drive(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sbq.push_back('{res: v.res, op: v.op, ill: v.ill});
    pushed++;
    @(negedge clk);
    chk("illegal_latency_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // SRA by 4 with SHIFT_STEP=1: valid 5 cycles after accept, no ready meanwhile
    v = vecs[17];
    send(v, 1'b1);
    lat = 1; rdy_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) rdy_hi++;
      lat++;
    end
    chk("sra_latency", lat, 32'd5);
    chk("sra_ready_low", rdy_hi, 32'd0);
    drain();

    // Same SRA on the SHIFT_STEP=4 instance: valid 2 cycles after accept
    drive(v);
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid4) break;
      lat++;
    end
    chk("sra4_latency", lat, 32'd2);
    chk("sra4_result", result4, 32'hF800_0000);
    chk("sra4_op", {28'd0, alu_op4}, 32'h7);
    @(posedge clk); #1;

    // Reset in the middle of SLL by 20 discards the partial result
    v = mk(2'b10, 3'b001, 7'd0, 1'b0, 32'd1, 32'd20, 32'd0, 4'b0100, 1'b0);
    send(v, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_result", result, 32'd0);
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("abort_no_output", vcount, 32'd0);
    @(posedge clk); #1;

    // Backpressure: three XORs, consumer stalled for 4 cycles
    out_ready = 1'b0;
    send(mk(2'b10, 3'b100, 7'd0, 1'b0, 32'h1, 32'h3, 32'h2, 4'b1000, 1'b0), 1'b1);
    fork
      begin
        send(mk(2'b10, 3'b100, 7'd0, 1'b0, 32'hA5, 32'h0F, 32'hAA, 4'b1000, 1'b0), 1'b1);
        send(mk(2'b10, 3'b100, 7'd0, 1'b0, 32'hFFFF_0000, 32'h00FF_FF00, 32'hFF00_FF00, 4'b1000, 1'b0), 1'b1);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
          chk("bp_result_held", result, 32'h2);
          chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 32'd0);
    chk("sb_delivered", delivered, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
